// File: rtl/apb_cmd_master_pkg4.sv
// rtl/apb_cmd_master_pkg4.sv - state type, slave-select constants and default watchdog limit for apb_cmd_master4
package apb_cmd_master_pkg4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int SEL_WIDTH              = 4;
    localparam int NUM_SLAVES             = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [SEL_WIDTH-1:0] sel);
        logic [NUM_SLAVES-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/apb_watchdog4.sv
// rtl/apb_watchdog4.sv - ACCESS wait-state watchdog, used by apb_cmd_master4 when APB_CMD_MASTER_TIMEOUT_EN is defined
module apb_watchdog4
    import apb_cmd_master_pkg4::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic pclock4,
    input  logic preset4,
    input  logic start,
    input  logic count_en,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt + CW'(1);

    // expired is raised one cycle early so it lines up with the final
    // allowed wait cycle; the master aborts at the end of that cycle.
    always_ff @(posedge pclock4 or negedge preset4) begin
        if (!preset4) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            expired <= (TIMEOUT_CYCLES == 1);
        end else if (count_en) begin
            cnt     <= cnt_inc;
            expired <= (cnt_inc == LAST);
        end else begin
            expired <= 1'b0;
        end
    end

endmodule

// File: rtl/apb_cmd_master4.sv
// rtl/apb_cmd_master4.sv - single-outstanding command-to-APB master; APB_CMD_MASTER_TIMEOUT_EN adds an ACCESS watchdog
module apb_cmd_master4
    import apb_cmd_master_pkg4::*;
#(
    parameter int PADDR_WIDTH4   = 32,
    parameter int PWDATA_WIDTH4  = 32,
    parameter int PRDATA_WIDTH4  = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      pclock4,
    input  logic                      preset4,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [PADDR_WIDTH4-1:0]   cmd_addr,
    input  logic [PWDATA_WIDTH4-1:0]  cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [PRDATA_WIDTH4-1:0]  rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic [PADDR_WIDTH4-1:0]   paddr4,
    output logic                      prwd4,
    output logic [PWDATA_WIDTH4-1:0]  pwdata4,
    output logic                      penable4,
    output logic [NUM_SLAVES-1:0]     psel4,
    input  logic [PRDATA_WIDTH4-1:0]  prdata4,
    input  logic                      pready4,
    input  logic                      pslverr4
);

    state_t                     state, state_d;
    logic                       cmd_ready_d;
    logic                       rsp_valid_d;
    logic                       rsp_err_d;
    logic [PRDATA_WIDTH4-1:0]   rsp_rdata_d;
    logic [PADDR_WIDTH4-1:0]    paddr_d;
    logic                       prwd_d;
    logic [PWDATA_WIDTH4-1:0]   pwdata_d;
    logic                       penable_d;
    logic [NUM_SLAVES-1:0]      psel_d;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    logic rsp_timeout_d;
    logic expired;

    apb_watchdog4 #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .pclock4  (pclock4),
        .preset4  (preset4),
        .start    (state == SETUP),
        .count_en ((state == ACCESS) && !pready4),
        .expired  (expired)
    );
`else
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state;
        rsp_valid_d = rsp_valid;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
        paddr_d     = paddr4;
        prwd_d      = prwd4;
        pwdata_d    = pwdata4;
        penable_d   = penable4;
        psel_d      = psel4;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    paddr_d  = cmd_addr;
                    prwd_d   = cmd_write;
                    pwdata_d = cmd_wdata;
                    psel_d   = slave_onehot(cmd_addr[PADDR_WIDTH4-1 -: SEL_WIDTH]);
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready4) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr4;
                    rsp_rdata_d = prwd4 ? '0 : prdata4;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d     = RESP;
                end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                else if (expired) begin
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered ready: high exactly in the cycles the FSM sits in IDLE.
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge pclock4 or negedge preset4) begin
        if (!preset4) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            paddr4    <= '0;
            prwd4     <= 1'b0;
            pwdata4   <= '0;
            penable4  <= 1'b0;
            psel4     <= '0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            paddr4    <= paddr_d;
            prwd4     <= prwd_d;
            pwdata4   <= pwdata_d;
            penable4  <= penable_d;
            psel4     <= psel_d;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            rsp_timeout <= rsp_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_cmd_master4.sv
// tb/tb_apb_cmd_master4.sv - randomized bench for apb_cmd_master4 against a transaction-timeline model; honours APB_CMD_MASTER_TIMEOUT_EN
module tb_apb_cmd_master4;

    localparam int TO = 8;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic        pclock4   = 1'b0;
    logic        preset4   = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic [31:0] prdata4   = '0;
    logic        pready4   = 1'b0;
    logic        pslverr4  = 1'b0;

    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, prwd4, penable4;
    logic [31:0] rsp_rdata, paddr4, pwdata4;
    logic [15:0] psel4;

    apb_cmd_master4 #(
        .PADDR_WIDTH4   (32),
        .PWDATA_WIDTH4  (32),
        .PRDATA_WIDTH4  (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclock4     (pclock4),
        .preset4     (preset4),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr4      (paddr4),
        .prwd4       (prwd4),
        .pwdata4     (pwdata4),
        .penable4    (penable4),
        .psel4       (psel4),
        .prdata4     (prdata4),
        .pready4     (pready4),
        .pslverr4    (pslverr4)
    );

    always #5 pclock4 = ~pclock4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge pclock4) cyc <= cyc + 1;

    // Transaction model: one outstanding command described by its handshake
    // cycle and wait count; every output follows from cycle arithmetic.
    bit          m_busy = 1'b0, m_reset_low = 1'b1, m_wr = 1'b0, m_perr = 1'b0, m_eerr = 1'b0, m_to = 1'b0;
    int          m_hs = 0, m_w = 0, m_weff = 0, m_ready_from = 0, d = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_data = '0, m_rdata = '0;
    int          plan_w = 0;
    logic [31:0] plan_data = '0;
    logic        plan_err = 1'b0;
    logic        e_ready, e_pen, e_rv;
    logic [15:0] e_psel;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge pclock4) begin
        if (!preset4) begin
            chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_err",   32'(rsp_err),   32'd0);
            chk("rst_rsp_to",    32'(rsp_timeout), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata,      32'd0);
            chk("rst_psel",      32'(psel4),     32'd0);
            chk("rst_penable",   32'(penable4),  32'd0);
            chk("rst_paddr",     paddr4,         32'd0);
            chk("rst_pwdata",    pwdata4,        32'd0);
            chk("rst_prwd",      32'(prwd4),     32'd0);
            m_busy = 1'b0; m_reset_low = 1'b1;
            m_addr = '0; m_wdata = '0; m_wr = 1'b0;
        end else begin
            if (m_reset_low) begin
                m_ready_from = cyc + 1;
                m_reset_low  = 1'b0;
            end
            e_ready = 1'b0; e_pen = 1'b0; e_rv = 1'b0; e_psel = '0;
            if (!m_busy) begin
                e_ready = (cyc >= m_ready_from);
            end else begin
                d = cyc - m_hs;
                if (d >= 3 + m_weff) begin
                    e_rv = 1'b1;
                end else begin
                    e_psel = 16'h1 << m_addr[31:28];
                    e_pen  = (d >= 2);
                end
            end
            chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("psel4",     32'(psel4),     32'(e_psel));
            chk("penable4",  32'(penable4),  32'(e_pen));
            chk("paddr4",    paddr4,         m_addr);
            chk("pwdata4",   pwdata4,        m_wdata);
            chk("prwd4",     32'(prwd4),     32'(m_wr));
            if (e_rv) begin
                chk("rsp_rdata",   rsp_rdata,          m_rdata);
                chk("rsp_err",     32'(rsp_err),       32'(m_eerr));
                chk("rsp_timeout", 32'(rsp_timeout),   32'(m_to));
            end
            if (e_ready && cmd_valid) begin
                m_busy  = 1'b1;
                m_hs    = cyc;
                m_addr  = cmd_addr;
                m_wr    = cmd_write;
                m_wdata = cmd_wdata;
                m_w     = plan_w;
                m_data  = plan_data;
                m_perr  = plan_err;
                m_to    = TO_ON && (plan_w >= TO);
                m_weff  = m_to ? TO - 1 : plan_w;
                m_eerr  = m_to | plan_err;
                m_rdata = (m_to || cmd_write) ? 32'h0 : plan_data;
            end else if (e_rv && rsp_ready) begin
                m_busy       = 1'b0;
                m_ready_from = cyc + 1;
            end
        end
    end

    // Slave: low pready for the planned wait count, noise on everything it may ignore.
    always @(posedge pclock4) begin
        #1;
        if (m_busy && cyc == m_hs + 2 + m_w) begin
            pready4  = 1'b1;
            prdata4  = m_data;
            pslverr4 = m_perr;
        end else begin
            prdata4  = $urandom;
            pslverr4 = 1'($urandom_range(0, 1));
            pready4  = (m_busy && cyc >= m_hs + 2 && cyc < m_hs + 2 + m_w) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    task automatic at_cycle(input int t);
        do @(negedge pclock4); while (cyc < t);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge pclock4);
            ok = cmd_ready;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL idle_wait: cmd_ready=%0b want 1 within 200 cycles", cmd_ready);
        end
        @(posedge pclock4); #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input int w, input logic [31:0] rd, input logic err, output int hs);
        plan_w = w; plan_data = rd; plan_err = err;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
        hs = -1;
        for (int i = 0; i < 50 && hs < 0; i++) begin
            @(negedge pclock4);
            if (cmd_ready) hs = cyc;
        end
        @(posedge pclock4); #1;
        cmd_valid = 1'b0;
        total++;
        if (hs < 0) begin
            bad++;
            $display("FAIL issue_handshake: cmd_ready=%0b want 1 within 50 cycles", cmd_ready);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time: bench still running at %0t want finished", $time);
        $fatal(1);
    end

    initial begin
        int hs;
        repeat (3) @(posedge pclock4);
        #1;
        chk("por_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("por_psel",      32'(psel4),     32'd0);
        preset4 = 1'b1;
        #1 chk("release_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge pclock4); #1;
        chk("first_edge_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1;

        // zero-wait write
        issue(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 0, 32'h0BAD_F00D, 1'b0, hs);
        if (hs >= 0) begin
            at_cycle(hs + 1);
            chk("t1_psel", 32'(psel4), 32'h0008);
            chk("t1_penable_setup", 32'(penable4), 32'd0);
            chk("t1_pwdata", pwdata4, 32'hDEAD_BEEF);
            at_cycle(hs + 2);
            chk("t1_penable_access", 32'(penable4), 32'd1);
            at_cycle(hs + 3);
            chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t1_rsp_err",   32'(rsp_err),   32'd0);
            chk("t1_rsp_rdata", rsp_rdata,      32'd0);
        end
        wait_idle();

        // read with three wait states
        issue(1'b0, 32'hF000_0004, 32'h0, 3, 32'h1234_5678, 1'b0, hs);
        if (hs >= 0) begin
            at_cycle(hs + 1);
            chk("t2_psel", 32'(psel4), 32'h8000);
            for (int k = 2; k <= 5; k++) begin
                at_cycle(hs + k);
                chk("t2_hold_penable", 32'(penable4), 32'd1);
                chk("t2_hold_paddr",   paddr4,        32'hF000_0004);
                chk("t2_hold_psel",    32'(psel4),    32'h8000);
                chk("t2_no_rsp",       32'(rsp_valid), 32'd0);
            end
            at_cycle(hs + 6);
            chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t2_rsp_rdata", rsp_rdata,      32'h1234_5678);
        end
        wait_idle();

        // slave error on a write
        issue(1'b1, 32'h1000_0000, 32'h5555_AAAA, 1, 32'hFFFF_FFFF, 1'b1, hs);
        if (hs >= 0) begin
            at_cycle(hs + 4);
            chk("t3_rsp_valid", 32'(rsp_valid),   32'd1);
            chk("t3_rsp_err",   32'(rsp_err),     32'd1);
            chk("t3_rsp_to",    32'(rsp_timeout), 32'd0);
            chk("t3_rsp_rdata", rsp_rdata,        32'd0);
        end
        wait_idle();

        // response back-pressure with a queued command
        rsp_ready = 1'b0;
        issue(1'b0, 32'h5000_0020, 32'h0, 0, 32'hA5A5_0F0F, 1'b0, hs);
        cmd_write = 1'b1; cmd_addr = 32'h2000_0000; cmd_wdata = 32'h0000_0077; cmd_valid = 1'b1;
        plan_w = 0; plan_err = 1'b0;
        if (hs >= 0) begin
            for (int k = 3; k <= 7; k++) begin
                at_cycle(hs + k);
                chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
                chk("t4_hold_rdata", rsp_rdata,      32'hA5A5_0F0F);
                chk("t4_cmd_ready",  32'(cmd_ready), 32'd0);
                chk("t4_no_setup",   32'(psel4),     32'd0);
            end
            @(posedge pclock4); #1;
            rsp_ready = 1'b1;
            at_cycle(hs + 8);
            chk("t4_accept_cmd_ready", 32'(cmd_ready), 32'd0);
            at_cycle(hs + 9);
            chk("t4_after_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("t4_after_rsp_valid", 32'(rsp_valid), 32'd0);
            @(posedge pclock4); #1;
            cmd_valid = 1'b0;
            at_cycle(hs + 10);
            chk("t4_next_psel", 32'(psel4), 32'h0004);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        wait_idle();

        // reset during ACCESS
        issue(1'b0, 32'h7000_0000, 32'h0, 10, 32'h1, 1'b0, hs);
        if (hs >= 0) begin
            at_cycle(hs + 3);
            #2 preset4 = 1'b0;
            #1;
            chk("t5_psel_async",    32'(psel4),    32'd0);
            chk("t5_penable_async", 32'(penable4), 32'd0);
            repeat (3) @(posedge pclock4);
            #1 preset4 = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge pclock4);
                chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
            end
        end
        wait_idle();

        // pready stuck low
        issue(1'b1, 32'hC000_0008, 32'h1111_2222, 200000, 32'h0, 1'b0, hs);
        if (hs >= 0) begin
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            at_cycle(hs + 9);
            chk("t6_last_access", 32'(penable4), 32'd1);
            at_cycle(hs + 10);
            chk("t6_rsp_valid", 32'(rsp_valid),   32'd1);
            chk("t6_rsp_err",   32'(rsp_err),     32'd1);
            chk("t6_rsp_to",    32'(rsp_timeout), 32'd1);
            chk("t6_psel",      32'(psel4),       32'd0);
`else
            at_cycle(hs + 1002);
            chk("t6_pending_penable", 32'(penable4),  32'd1);
            chk("t6_pending_psel",    32'(psel4),     32'h1000);
            chk("t6_pending_rsp",     32'(rsp_valid), 32'd0);
            @(posedge pclock4); #1 preset4 = 1'b0;
            repeat (2) @(posedge pclock4);
            #1 preset4 = 1'b1;
`endif
        end
        wait_idle();

        for (int i = 0; i < 2000; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 2) != 0);
            plan_w    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 3));
            plan_data = $urandom;
            plan_err  = ($urandom_range(0, 3) == 0);
            @(posedge pclock4); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
